// File: rtl/dot_product_pkg.sv
// dot_product_pkg: shared states, default sizes and count width helper for the dot product datapath
package dot_product_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam int DEF_BIT_WIDTH = 8;
    localparam int DEF_VEC_LEN   = 4;
    localparam int DEF_ACC_WIDTH = 16;

    // count only needs to reach VEC_LEN-1; keep at least one bit
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_CNT_WIDTH = cnt_width(DEF_VEC_LEN);

endpackage

// File: rtl/carry_ripple_adder.sv
// carry_ripple_adder: ripple-carry two's-complement adder with signed overflow and sign flags
module carry_ripple_adder #(
    parameter int BIT_WIDTH = 8
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 overflow,
    output logic                 negative
);

    logic [BIT_WIDTH:0] c;

    assign c[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < BIT_WIDTH; i++) begin : g_fa
            assign sum[i]   = a[i] ^ b[i] ^ c[i];
            assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    // signed overflow: carry into the sign bit differs from carry out of it
    assign overflow = c[BIT_WIDTH] ^ c[BIT_WIDTH-1];
    assign negative = sum[BIT_WIDTH-1];

endmodule

// File: rtl/dot_product_ctrl.sv
// dot_product_ctrl: streams element pairs, accumulates signed products, presents result on valid/ready
module dot_product_ctrl
    import dot_product_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int VEC_LEN   = DEF_VEC_LEN,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [BIT_WIDTH-1:0] a,
    input  logic signed [BIT_WIDTH-1:0] b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic        [ACC_WIDTH-1:0] result,
    output logic                        overflow,
    output logic                        negative,
    output logic                        busy
);

    localparam int CNT_W = cnt_width(VEC_LEN);
    localparam int PROD_W = 2 * BIT_WIDTH;

    state_t                     state;
    logic        [ACC_WIDTH-1:0] acc;
    logic        [CNT_W-1:0]     count;
    logic signed [PROD_W-1:0]    prod_full;
    logic signed [ACC_WIDTH-1:0] product;
    logic        [ACC_WIDTH-1:0] sum;
    logic                        add_ovf;
    logic                        add_neg;
    logic                        beat;
    logic                        last;

    assign prod_full = PROD_W'(a) * PROD_W'(b);
    assign product   = ACC_WIDTH'(prod_full);
    assign beat      = in_valid && in_ready;
    assign last      = count == CNT_W'(VEC_LEN - 1);

    carry_ripple_adder #(
        .BIT_WIDTH(ACC_WIDTH)
    ) u_adder (
        .a       (acc),
        .b       (product),
        .sum     (sum),
        .overflow(add_ovf),
        .negative(add_neg)
    );

    // sequencer: all outputs are registered and decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            result    <= '0;
            overflow  <= 1'b0;
            negative  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc      <= sum;
                        overflow <= overflow | add_ovf;
                        count    <= count + CNT_W'(1);
                        if (last) begin
                            result    <= sum;
                            negative  <= add_neg;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_ctrl.sv
// tb_dot_product_ctrl: directed and randomized vectors checked against an integer reference model
module tb_dot_product_ctrl;

    localparam int BW = 8;
    localparam int VL = 4;
    localparam int AW = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [BW-1:0] a = '0;
    logic signed [BW-1:0] b = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic        [AW-1:0] result;
    logic                 overflow;
    logic                 negative;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int va[VL];
    int vb[VL];

    dot_product_ctrl #(
        .BIT_WIDTH(BW),
        .VEC_LEN  (VL),
        .ACC_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .overflow (overflow),
        .negative (negative),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // running integer sum, wrapped to 16-bit signed after each step; overflow when a step leaves the range
    function automatic void ref_dot(input int av[VL], input int bv[VL], output logic [AW-1:0] r, output logic o);
        int acc;
        int s;
        acc = 0;
        o   = 1'b0;
        for (int i = 0; i < VL; i++) begin
            s = acc + av[i] * bv[i];
            if (s > 32767 || s < -32768) o = 1'b1;
            acc = (s > 32767) ? s - 65536 : (s < -32768) ? s + 65536 : s;
        end
        r = acc[AW-1:0];
    endfunction

    task automatic do_vector(input string name, input int av[VL], input int bv[VL],
                             input int gap, input int hold, input bit poke);
        logic [AW-1:0] er;
        logic          eo;
        ref_dot(av, bv, er, eo);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, " busy after start"}, 32'(busy), 32'd1);
        check({name, " in_ready in accum"}, 32'(in_ready), 32'd1);
        for (int i = 0; i < VL; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                start    = poke;
                @(negedge clk);
                start = 1'b0;
                check({name, " gap in_ready"}, 32'(in_ready), 32'd1);
                check({name, " gap out_valid"}, 32'(out_valid), 32'd0);
            end
            in_valid = 1'b1;
            a        = av[i][BW-1:0];
            b        = bv[i][BW-1:0];
            @(negedge clk);
            in_valid = 1'b0;
            if (i < VL - 1) check({name, " early out_valid"}, 32'(out_valid), 32'd0);
        end
        check({name, " out_valid"}, 32'(out_valid), 32'd1);
        check({name, " result"}, 32'(result), 32'(er));
        check({name, " overflow"}, 32'(overflow), 32'(eo));
        check({name, " negative"}, 32'(negative), 32'(er[AW-1]));
        check({name, " in_ready done"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            start = poke;
            @(negedge clk);
            start = 1'b0;
            check({name, " held out_valid"}, 32'(out_valid), 32'd1);
            check({name, " held result"}, 32'(result), 32'(er));
            check({name, " held in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        start     = poke;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check({name, " out_valid dropped"}, 32'(out_valid), 32'd0);
        check({name, " idle busy"}, 32'(busy), 32'd0);
        check({name, " idle result kept"}, 32'(result), 32'(er));
        @(negedge clk);
        check({name, " start ignored"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        check("rst negative", 32'(negative), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        va = '{1, 2, 3, 4};
        vb = '{5, 6, 7, 8};
        do_vector("basic", va, vb, 0, 0, 1'b0);

        va = '{-3, 10, -128, 0};
        vb = '{4, -2, 1, 127};
        do_vector("mixed", va, vb, 0, 0, 1'b0);

        va = '{-128, -128, -128, -128};
        vb = '{-128, -128, -128, -128};
        do_vector("wrap", va, vb, 0, 0, 1'b0);

        va = '{1, 2, 3, 4};
        vb = '{5, 6, 7, 8};
        do_vector("backpressure", va, vb, 2, 3, 1'b1);

        // abandon a vector after two beats
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a        = 8'sd9;
            b        = 8'sd9;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd0);
        check("midrst result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check("midrst no out_valid", 32'(out_valid), 32'd0);
            check("midrst in_ready idle", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        va = '{1, 1, 1, 1};
        vb = '{2, 2, 2, 2};
        do_vector("after_rst", va, vb, 0, 0, 1'b0);

        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < VL; i++) begin
                va[i] = int'($urandom_range(0, 255)) - 128;
                vb[i] = int'($urandom_range(0, 255)) - 128;
            end
            do_vector("random", va, vb, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                      1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
